i2c_codec_responder: RTL and testbench

//  Synthesizable I2C target (slave) that mimics the WM8731-style codec control port.
//  It accepts the 3-byte write frames sent by the I2C configuration master and mirrors them into a local register file.

---
 rtl/i2c_codec_pkg.sv | 27 ++
 rtl/i2c_bus_sync.sv | 48 ++++
 rtl/i2c_codec_responder.sv | 196 +++++++++++++++++++
 tb/tb_i2c_codec_responder.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_codec_pkg.sv
// Shared definitions for the WM8731-style I2C codec control-port responder.
// Holds the FSM state encoding, the target address default and the
// power-on values loaded into the register file at reset and by a write
// to the reset register.
package i2c_codec_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_ACK_A  = 3'd2,
    ST_BYTE_H = 3'd3,
    ST_ACK_H  = 3'd4,
    ST_BYTE_L = 3'd5,
    ST_ACK_L  = 3'd6,
    ST_IGNORE = 3'd7
  } state_e;

  localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h1A;

  // WM8731 power-on register values (R0..R9); R10..R15 are unused or
  // write-only and read back as zero.
  localparam logic [8:0] DEFAULTS [0:15] = '{
    9'h097, 9'h097, 9'h079, 9'h079, 9'h00A, 9'h008, 9'h09F, 9'h00A,
    9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000
  };

endpackage

// File: rtl/i2c_bus_sync.sv
// Brings the asynchronous I2C pins into the clk domain and detects bus events.
// Ports:
//   clk, reset          system clock, asynchronous active-low reset
//   scl_in, sda_in      raw SCL / SDA pin levels
//   scl_rise, scl_fall  one-cycle SCL edge pulses
//   start_det, stop_det one-cycle START / STOP condition pulses
//   sda_s               synchronised SDA, aligned with the edge pulses
module i2c_bus_sync (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  // Bits [1:0] form the two-flop synchroniser, bit [2] holds the previous
  // synchronised level for edge detection.
  logic [2:0] scl_q, scl_d;
  logic [2:0] sda_q, sda_d;

  // Next value of the synchroniser / history chains.
  always_comb begin
    scl_d = {scl_q[1:0], scl_in};
    sda_d = {sda_q[1:0], sda_in};
  end

  // Chain registers; reset to the idle-bus level so no spurious edge appears.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= scl_d;
      sda_q <= sda_d;
    end
  end

  assign scl_rise  = scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] & scl_q[2];
  assign start_det = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
  assign stop_det  = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];
  assign sda_s     = sda_q[1];

endmodule

// File: rtl/i2c_codec_responder.sv
// I2C target emulating the WM8731 control port. Accepts 3-byte write frames
// {addr+W, reg_addr[6:0]+data[8], data[7:0]} and mirrors them into a local
// register file.
// Ports:
//   clk, reset      50 MHz system clock, asynchronous active-low reset
//   i2c_sclk        bus SCL (asynchronous)
//   i2c_sdat_in     bus SDA from the pad
//   i2c_sdat_oe     1 = pull SDA low
//   reg_wr          one-cycle commit strobe
//   reg_addr/data   address/data of the last committed frame
//   rd_addr/rd_data combinational register file read port
//   err_nack        sticky NACK flag, cleared by a matching address byte
module i2c_codec_responder
  import i2c_codec_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR  = DEV_ADDR_DEFAULT,
  parameter int         NUM_REGS  = 16,
  parameter logic [6:0] RESET_REG = 7'h0F
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i2c_sclk,
  input  logic       i2c_sdat_in,
  output logic       i2c_sdat_oe,
  output logic       reg_wr,
  output logic [6:0] reg_addr,
  output logic [8:0] reg_data,
  input  logic [3:0] rd_addr,
  output logic [8:0] rd_data,
  output logic       err_nack
);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] hi_q, hi_d;
  logic       oe_q, oe_d;
  logic       err_q, err_d;
  logic       reg_wr_q, reg_wr_d;
  logic [6:0] reg_addr_q, reg_addr_d;
  logic [8:0] reg_data_q, reg_data_d;
  logic [8:0] regs_q [NUM_REGS];
  logic [8:0] regs_d [NUM_REGS];

  i2c_bus_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .scl_in    (i2c_sclk),
    .sda_in    (i2c_sdat_in),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  // Protocol FSM, shifter, bit counter and commit strobe.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    hi_d       = hi_q;
    oe_d       = oe_q;
    err_d      = err_q;
    reg_wr_d   = 1'b0;
    reg_addr_d = reg_addr_q;
    reg_data_d = reg_data_q;
    if (start_det) begin
      state_d   = ST_ADDR;
      bit_cnt_d = 3'd0;
      oe_d      = 1'b0;
    end else if (stop_det) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 3'd0;
      oe_d      = 1'b0;
    end else begin
      case (state_q)
        // IGNORE keeps counting bits so a whole unacknowledged byte can be flagged.
        ST_ADDR, ST_BYTE_H, ST_BYTE_L, ST_IGNORE: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              case (state_q)
                ST_ADDR: begin
                  if ((shift_d[7:1] == DEV_ADDR) && !shift_d[0]) begin
                    state_d = ST_ACK_A;
                    err_d   = 1'b0;
                  end else begin
                    state_d = ST_IGNORE;
                    err_d   = 1'b1;
                  end
                end
                ST_BYTE_H: begin
                  hi_d    = shift_d;
                  state_d = ST_ACK_H;
                end
                ST_BYTE_L: state_d = ST_ACK_L;
                default:   err_d   = 1'b1;
              endcase
            end else begin
              state_d = state_q;
            end
          end else begin
            shift_d = shift_q;
          end
        end
        // First SCL fall after bit 8 starts driving ACK, the next one ends it.
        ST_ACK_A, ST_ACK_H, ST_ACK_L: begin
          if (scl_fall) begin
            if (!oe_q) begin
              oe_d = 1'b1;
            end else begin
              oe_d      = 1'b0;
              bit_cnt_d = 3'd0;
              case (state_q)
                ST_ACK_A: state_d = ST_BYTE_H;
                ST_ACK_H: state_d = ST_BYTE_L;
                default: begin
                  state_d    = ST_IGNORE;
                  reg_wr_d   = 1'b1;
                  reg_addr_d = hi_q[7:1];
                  reg_data_d = {hi_q[0], shift_q};
                end
              endcase
            end
          end else begin
            oe_d = oe_q;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Register file update, driven from the registered commit one cycle later.
  always_comb begin
    regs_d = regs_q;
    if (reg_wr_q) begin
      if (reg_addr_q == RESET_REG) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          regs_d[i] = DEFAULTS[i];
        end
      end else begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (int'(reg_addr_q) == i) begin
            regs_d[i] = reg_data_q;
          end else begin
            regs_d[i] = regs_q[i];
          end
        end
      end
    end else begin
      regs_d = regs_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      hi_q       <= 8'h00;
      oe_q       <= 1'b0;
      err_q      <= 1'b0;
      reg_wr_q   <= 1'b0;
      reg_addr_q <= 7'h00;
      reg_data_q <= 9'h000;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= DEFAULTS[i];
      end
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      hi_q       <= hi_d;
      oe_q       <= oe_d;
      err_q      <= err_d;
      reg_wr_q   <= reg_wr_d;
      reg_addr_q <= reg_addr_d;
      reg_data_q <= reg_data_d;
      regs_q     <= regs_d;
    end
  end

  assign i2c_sdat_oe = oe_q;
  assign reg_wr      = reg_wr_q;
  assign reg_addr    = reg_addr_q;
  assign reg_data    = reg_data_q;
  assign err_nack    = err_q;
  assign rd_data     = regs_q[rd_addr];

endmodule

// File: tb/tb_i2c_codec_responder.sv
// Self-checking bench for i2c_codec_responder: a bit-banged I2C master drives
// frames, a frame-level model predicts ACKs, commits, err_nack and the
// register file contents.
module tb_i2c_codec_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic       scl_m, sda_m, bus_sda;
  logic       i2c_sdat_oe, reg_wr, err_nack;
  logic [6:0] reg_addr;
  logic [8:0] reg_data, rd_data;
  logic [3:0] rd_addr;

  assign bus_sda = sda_m & ~i2c_sdat_oe;

  i2c_codec_responder dut (
    .clk         (clk),
    .reset       (reset),
    .i2c_sclk    (scl_m),
    .i2c_sdat_in (bus_sda),
    .i2c_sdat_oe (i2c_sdat_oe),
    .reg_wr      (reg_wr),
    .reg_addr    (reg_addr),
    .reg_data    (reg_data),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .err_nack    (err_nack)
  );

  always #10 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int q_clk = 10;

  // reg_wr / oe activity monitor
  int wr_cnt = 0, run = 0, max_run = 0, oe_cyc = 0;
  always @(negedge clk) begin
    if (reg_wr) begin
      wr_cnt <= wr_cnt + 1;
      run    <= run + 1;
      if (run + 1 > max_run) max_run <= run + 1;
    end else begin
      run <= 0;
    end
    if (i2c_sdat_oe) oe_cyc <= oe_cyc + 1;
  end

  // ---------------- reference model ----------------
  logic [8:0] m_regs [16];
  logic       m_err;
  logic [6:0] m_addr;
  logic [8:0] m_data;
  int         m_wr = 0;
  logic [7:0] tx_q[$];
  bit         ack_q[$];
  bit         exp_ack_q[$];

  function automatic logic [8:0] wm_default(input int i);
    case (i)
      0, 1:    return 9'h097;
      2, 3:    return 9'h079;
      4:       return 9'h00A;
      5:       return 9'h008;
      6:       return 9'h09F;
      7:       return 9'h00A;
      default: return 9'h000;
    endcase
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 16; r++) m_regs[r] = wm_default(r);
    m_err  = 1'b0;
    m_addr = 7'h00;
    m_data = 9'h000;
  endtask

  // Predict the outcome of the complete frame in tx_q followed by STOP.
  task automatic model_frame();
    exp_ack_q.delete();
    if (tx_q[0] != 8'h34) begin
      m_err = 1'b1;
      foreach (tx_q[i]) exp_ack_q.push_back(1'b0);
    end else begin
      m_err = 1'b0;
      foreach (tx_q[i]) exp_ack_q.push_back(i < 3);
      if (tx_q.size() > 3) m_err = 1'b1;
      if (tx_q.size() >= 3) begin
        m_wr++;
        m_addr = tx_q[1][7:1];
        m_data = {tx_q[1][0], tx_q[2]};
        if (m_addr == 7'h0F) begin
          for (int r = 0; r < 16; r++) m_regs[r] = wm_default(r);
        end else if (m_addr < 7'd16) begin
          m_regs[m_addr[3:0]] = m_data;
        end
      end
    end
  endtask

  // ---------------- bus master ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wait_clk(q_clk);
    scl_m = 1'b1; wait_clk(q_clk);
    sda_m = 1'b0; wait_clk(q_clk);
    scl_m = 1'b0; wait_clk(q_clk);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_clk(q_clk);
    scl_m = 1'b1; wait_clk(q_clk);
    sda_m = 1'b1; wait_clk(2 * q_clk);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;    wait_clk(q_clk);
    scl_m = 1'b1; wait_clk(2 * q_clk);
    scl_m = 1'b0; wait_clk(q_clk);
  endtask

  task automatic send_byte(input logic [7:0] b, output bit ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m = 1'b1; wait_clk(q_clk);
    scl_m = 1'b1; wait_clk(q_clk);
    ack = ~bus_sda;
    wait_clk(q_clk);
    scl_m = 1'b0; wait_clk(q_clk);
  endtask

  task automatic send_frame();
    bit a;
    ack_q.delete();
    bus_start();
    foreach (tx_q[i]) begin
      send_byte(tx_q[i], a);
      ack_q.push_back(a);
    end
    bus_stop();
    wait_clk(10);
    #2;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0; scl_m = 1'b1; sda_m = 1'b1; rd_addr = 4'd0;
    model_reset();
    wait_clk(4); #2;
    n_chk++; if (i2c_sdat_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe got %0b want 0", i2c_sdat_oe); end
    n_chk++; if (reg_wr !== 1'b0) begin n_fail++; $display("FAIL reset_reg_wr got %0b want 0", reg_wr); end
    n_chk++; if (reg_addr !== 7'h00 || reg_data !== 9'h000) begin n_fail++; $display("FAIL reset_addr_data got %h/%h want 00/000", reg_addr, reg_data); end
    n_chk++; if (err_nack !== 1'b0) begin n_fail++; $display("FAIL reset_err got %0b want 0", err_nack); end
    for (int r = 0; r < 16; r++) begin
      rd_addr = r[3:0]; #1;
      n_chk++; if (rd_data !== wm_default(r)) begin n_fail++; $display("FAIL reset_reg%0d got %h want %h", r, rd_data, wm_default(r)); end
    end
    reset = 1'b1;
    wait_clk(5);
  endtask

  task automatic test_write();
    q_clk = 125;  // 100 kHz SCL at 50 MHz clk
    tx_q = '{8'h34, 8'h0C, 8'h10};
    model_frame();
    send_frame();
    q_clk = 10;
    foreach (exp_ack_q[i]) begin
      n_chk++; if (ack_q[i] !== exp_ack_q[i]) begin n_fail++; $display("FAIL write_ack%0d got %0b want %0b", i, ack_q[i], exp_ack_q[i]); end
    end
    n_chk++; if (wr_cnt !== m_wr) begin n_fail++; $display("FAIL write_wr_cnt got %0d want %0d", wr_cnt, m_wr); end
    n_chk++; if (max_run !== 1) begin n_fail++; $display("FAIL write_pulse_width got %0d want 1", max_run); end
    n_chk++; if (reg_addr !== 7'h06 || reg_data !== 9'h010) begin n_fail++; $display("FAIL write_addr_data got %h/%h want 06/010", reg_addr, reg_data); end
    rd_addr = 4'd6; #1;
    n_chk++; if (rd_data !== 9'h010) begin n_fail++; $display("FAIL write_rd6 got %h want 010", rd_data); end
  endtask

  task automatic test_bad_addr();
    int oe0;
    oe0 = oe_cyc;
    tx_q = '{8'h36, 8'h0C, 8'h99};
    model_frame();
    send_frame();
    foreach (exp_ack_q[i]) begin
      n_chk++; if (ack_q[i] !== exp_ack_q[i]) begin n_fail++; $display("FAIL badaddr_ack%0d got %0b want %0b", i, ack_q[i], exp_ack_q[i]); end
    end
    n_chk++; if (oe_cyc !== oe0) begin n_fail++; $display("FAIL badaddr_oe_cycles got %0d want %0d", oe_cyc - oe0, 0); end
    n_chk++; if (err_nack !== m_err) begin n_fail++; $display("FAIL badaddr_err got %0b want %0b", err_nack, m_err); end
    n_chk++; if (wr_cnt !== m_wr) begin n_fail++; $display("FAIL badaddr_wr_cnt got %0d want %0d", wr_cnt, m_wr); end
    tx_q = '{8'h34, 8'h04, 8'h2A};
    model_frame();
    send_frame();
    n_chk++; if (err_nack !== m_err) begin n_fail++; $display("FAIL badaddr_err_clear got %0b want %0b", err_nack, m_err); end
    n_chk++; if (reg_addr !== m_addr || reg_data !== m_data) begin n_fail++; $display("FAIL badaddr_next got %h/%h want %h/%h", reg_addr, reg_data, m_addr, m_data); end
  endtask

  task automatic test_read_and_extra();
    tx_q = '{8'h35};
    model_frame();
    send_frame();
    n_chk++; if (ack_q[0] !== 1'b0) begin n_fail++; $display("FAIL read_ack got %0b want 0", ack_q[0]); end
    n_chk++; if (err_nack !== m_err) begin n_fail++; $display("FAIL read_err got %0b want %0b", err_nack, m_err); end
    tx_q = '{8'h34, 8'h0C, 8'h10, 8'hFF};
    model_frame();
    send_frame();
    foreach (exp_ack_q[i]) begin
      n_chk++; if (ack_q[i] !== exp_ack_q[i]) begin n_fail++; $display("FAIL extra_ack%0d got %0b want %0b", i, ack_q[i], exp_ack_q[i]); end
    end
    n_chk++; if (err_nack !== m_err) begin n_fail++; $display("FAIL extra_err got %0b want %0b", err_nack, m_err); end
    n_chk++; if (wr_cnt !== m_wr) begin n_fail++; $display("FAIL extra_wr_cnt got %0d want %0d", wr_cnt, m_wr); end
  endtask

  task automatic test_partial();
    bit a;
    tx_q = '{8'h34, 8'h0C};
    model_frame();
    send_frame();
    n_chk++; if (wr_cnt !== m_wr) begin n_fail++; $display("FAIL partial_wr_cnt got %0d want %0d", wr_cnt, m_wr); end
    // repeated START in the middle of a data byte
    bus_start();
    send_byte(8'h34, a);
    n_chk++; if (a !== 1'b1) begin n_fail++; $display("FAIL rstart_addr_ack got %0b want 1", a); end
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    tx_q = '{8'h34, 8'h0A, 8'h5C};
    model_frame();
    send_frame();
    n_chk++; if (wr_cnt !== m_wr) begin n_fail++; $display("FAIL rstart_wr_cnt got %0d want %0d", wr_cnt, m_wr); end
    n_chk++; if (reg_addr !== m_addr || reg_data !== m_data) begin n_fail++; $display("FAIL rstart_addr_data got %h/%h want %h/%h", reg_addr, reg_data, m_addr, m_data); end
  endtask

  task automatic test_reset_reg();
    tx_q = '{8'h34, 8'h1E, 8'h00};
    model_frame();
    send_frame();
    n_chk++; if (reg_addr !== 7'h0F) begin n_fail++; $display("FAIL resetreg_addr got %h want 0f", reg_addr); end
    n_chk++; if (wr_cnt !== m_wr) begin n_fail++; $display("FAIL resetreg_wr_cnt got %0d want %0d", wr_cnt, m_wr); end
    for (int r = 0; r < 16; r++) begin
      rd_addr = r[3:0]; #1;
      n_chk++; if (rd_data !== m_regs[r]) begin n_fail++; $display("FAIL resetreg_reg%0d got %h want %h", r, rd_data, m_regs[r]); end
    end
  endtask

  task automatic test_random();
    logic [8:0] d;
    logic [6:0] ra;
    q_clk = 8;
    for (int f = 0; f < 14; f++) begin
      ra = 7'($urandom_range(0, 20));
      d  = 9'($urandom_range(0, 511));
      tx_q.delete();
      case ($urandom_range(0, 9))
        0:       tx_q.push_back(8'h35);
        1:       tx_q.push_back(8'($urandom_range(0, 255)) | 8'h80);
        default: tx_q.push_back(8'h34);
      endcase
      tx_q.push_back({ra, d[8]});
      tx_q.push_back(d[7:0]);
      if ($urandom_range(0, 4) == 0) tx_q.push_back(8'($urandom_range(0, 255)));
      model_frame();
      send_frame();
      foreach (exp_ack_q[i]) begin
        n_chk++; if (ack_q[i] !== exp_ack_q[i]) begin n_fail++; $display("FAIL rand%0d_ack%0d got %0b want %0b", f, i, ack_q[i], exp_ack_q[i]); end
      end
      n_chk++; if (err_nack !== m_err) begin n_fail++; $display("FAIL rand%0d_err got %0b want %0b", f, err_nack, m_err); end
      n_chk++; if (wr_cnt !== m_wr) begin n_fail++; $display("FAIL rand%0d_wr_cnt got %0d want %0d", f, wr_cnt, m_wr); end
      n_chk++; if (reg_addr !== m_addr || reg_data !== m_data) begin n_fail++; $display("FAIL rand%0d_addr_data got %h/%h want %h/%h", f, reg_addr, reg_data, m_addr, m_data); end
    end
    for (int r = 0; r < 16; r++) begin
      rd_addr = r[3:0]; #1;
      n_chk++; if (rd_data !== m_regs[r]) begin n_fail++; $display("FAIL rand_reg%0d got %h want %h", r, rd_data, m_regs[r]); end
    end
    n_chk++; if (max_run !== 1) begin n_fail++; $display("FAIL rand_pulse_width got %0d want 1", max_run); end
    q_clk = 10;
  endtask

  task automatic test_reset_mid_frame();
    bit a, got;
    logic [7:0] b;
    b = 8'h0C;
    bus_start();
    send_byte(8'h34, a);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      if (i2c_sdat_oe) got = 1'b1;
      else wait_clk(1);
    end
    n_chk++; if (!got) begin n_fail++; $display("FAIL midreset_ack_h_oe got 0 want 1 (timeout)"); end
    reset = 1'b0;
    model_reset();
    #1;
    n_chk++; if (i2c_sdat_oe !== 1'b0) begin n_fail++; $display("FAIL midreset_oe got %0b want 0", i2c_sdat_oe); end
    n_chk++; if (reg_wr !== 1'b0 || err_nack !== 1'b0) begin n_fail++; $display("FAIL midreset_flags got %0b/%0b want 0/0", reg_wr, err_nack); end
    n_chk++; if (reg_addr !== 7'h00 || reg_data !== 9'h000) begin n_fail++; $display("FAIL midreset_addr_data got %h/%h want 00/000", reg_addr, reg_data); end
    for (int r = 0; r < 16; r++) begin
      rd_addr = r[3:0]; #1;
      n_chk++; if (rd_data !== m_regs[r]) begin n_fail++; $display("FAIL midreset_reg%0d got %h want %h", r, rd_data, m_regs[r]); end
    end
    wait_clk(3);
    reset = 1'b1;
    wait_clk(3);
    bus_stop();
    tx_q = '{8'h34, 8'h0E, 8'h55};
    model_frame();
    send_frame();
    n_chk++; if (wr_cnt !== m_wr) begin n_fail++; $display("FAIL midreset_next_wr_cnt got %0d want %0d", wr_cnt, m_wr); end
    n_chk++; if (reg_addr !== m_addr || reg_data !== m_data) begin n_fail++; $display("FAIL midreset_next got %h/%h want %h/%h", reg_addr, reg_data, m_addr, m_data); end
    rd_addr = 4'd7; #1;
    n_chk++; if (rd_data !== m_regs[7]) begin n_fail++; $display("FAIL midreset_rd7 got %h want %h", rd_data, m_regs[7]); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_bad_addr();
    test_read_and_extra();
    test_partial();
    test_reset_reg();
    test_random();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
